trm_uart_io: RTL and testbench

TRM_UART_IO -- requirements
Module: trm_uart_io

---
 rtl/trm_uart_io_pkg.sv | 25 ++
 rtl/trm_sync_fifo.sv | 44 ++++
 rtl/trm_uart_io.sv | 228 ++++++++++++++++++++++
 tb/tb_trm_uart_io.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trm_uart_io_pkg.sv
// rtl/trm_uart_io_pkg.sv - register offsets, STATUS bit indices and FSM state encodings
package trm_uart_io_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_FRAME    = 4;
  localparam int ST_TX_OVF   = 5;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/trm_sync_fifo.sv
// rtl/trm_sync_fifo.sv - DEPTH x 8 synchronous FIFO with combinational read head
module trm_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trm_uart_io.sv
// rtl/trm_uart_io.sv - memory-mapped UART with TX/RX FIFOs, sticky status and level irq
module trm_uart_io
  import trm_uart_io_pkg::*;
#(
  parameter logic [5:0]  ABASE   = 6'd0,
  parameter int          DEPTH   = 16,
  parameter logic [15:0] DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ioadr,
  input  logic        iowr,
  input  logic        iord,
  input  logic [31:0] outbus,
  output logic [31:0] inbus,
  output logic        irq,
  output logic        txd,
  input  logic        rxd
);

  logic [5:0]  off;
  logic        sel;
  logic        wr_data, wr_status, wr_ctrl, wr_div, rd_pop;
  logic        phase;
  logic [1:0]  ctrl;
  logic [15:0] div;
  logic        overrun, frame_err, tx_ovf;
  logic [5:0]  status;
  logic        unused_bits;

  logic [7:0]  tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_idle;

  uart_state_t tx_state, tx_next;
  logic [15:0] tx_cnt, tx_len;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_pop;

  uart_state_t rx_state, rx_next;
  logic [15:0] rx_cnt, rx_len;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_s1, rx_s2, rx_prev, rx_fall;
  logic        rx_sample, rx_push, rx_ferr;

  assign off         = ioadr - ABASE;
  assign sel         = (off[5:2] == 4'd0);
  assign wr_data     = iowr && sel && (off[1:0] == OFF_DATA);
  assign wr_status   = iowr && sel && (off[1:0] == OFF_STATUS);
  assign wr_ctrl     = iowr && sel && (off[1:0] == OFF_CTRL);
  assign wr_div      = iowr && sel && (off[1:0] == OFF_DIV);
  // A load spans two cycles; popping only in the second keeps inbus stable throughout.
  assign rd_pop      = iord && sel && (off[1:0] == OFF_DATA) && phase;
  assign tx_idle     = tx_empty && (tx_state == S_IDLE);
  assign unused_bits = ^outbus[31:16];

  trm_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_data), .wdata(outbus[7:0]), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  trm_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift), .pop(rd_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status              = '0;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_IDLE]  = tx_idle;
    status[ST_OVERRUN]  = overrun;
    status[ST_FRAME]    = frame_err;
    status[ST_TX_OVF]   = tx_ovf;
  end

  always_comb begin
    inbus = '0;
    if (iord && sel) begin
      case (off[1:0])
        OFF_DATA:   inbus = rx_empty ? 32'd0 : {24'd0, rx_head};
        OFF_STATUS: inbus = {26'd0, status};
        OFF_CTRL:   inbus = {30'd0, ctrl};
        default:    inbus = {16'd0, div};
      endcase
    end
  end

  // Sticky sets are OR-ed after the clear so a same-cycle set survives a STATUS write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= 1'b0;
      ctrl      <= 2'd0;
      div       <= DIV_RST;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      phase     <= iord ? !phase : 1'b0;
      if (wr_ctrl) ctrl <= outbus[1:0];
      if (wr_div)  div  <= (outbus[15:0] < DIV_MIN) ? DIV_MIN : outbus[15:0];
      overrun   <= (overrun && !wr_status) || (rx_push && rx_full && !rd_pop);
      frame_err <= (frame_err && !wr_status) || rx_ferr;
      tx_ovf    <= (tx_ovf && !wr_status) || (wr_data && tx_full && !tx_pop);
      irq       <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_idle);
    end
  end

  assign tx_bit_end = (tx_cnt == tx_len - 16'd1);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE:  if (!tx_empty) begin
                 tx_next = S_START;
                 tx_pop  = 1'b1;
               end
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && (tx_idx == 3'd7)) tx_next = S_STOP;
      default: if (tx_bit_end) tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= S_IDLE;
    else      tx_state <= tx_next;
  end

  // Bit length is latched at each bit boundary so a DIV write never cuts a bit short.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_cnt   <= '0;
      tx_len   <= DIV_RST;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else if (tx_state == S_IDLE) begin
      tx_cnt <= '0;
      tx_len <= div;
      tx_idx <= '0;
      if (tx_pop) begin
        tx_shift <= tx_head;
        txd      <= 1'b0;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      tx_len <= div;
      if (tx_state == S_START) begin
        txd <= tx_shift[0];
      end else if (tx_state == S_DATA) begin
        tx_idx   <= tx_idx + 3'd1;
        tx_shift <= {1'b0, tx_shift[7:1]};
        txd      <= (tx_idx == 3'd7) ? 1'b1 : tx_shift[1];
      end else begin
        txd <= 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    rx_push   = 1'b0;
    rx_ferr   = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_cnt == {1'b0, rx_len[15:1]}) begin
                 rx_sample = 1'b1;
                 rx_next   = rx_s2 ? S_IDLE : S_DATA;
               end
      S_DATA:  if (rx_cnt == rx_len - 16'd1) begin
                 rx_sample = 1'b1;
                 if (rx_idx == 3'd7) rx_next = S_STOP;
               end
      default: if (rx_cnt == rx_len - 16'd1) begin
                 rx_sample = 1'b1;
                 rx_next   = S_IDLE;
                 rx_push   = rx_s2;
                 rx_ferr   = !rx_s2;
               end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= S_IDLE;
    else      rx_state <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt   <= '0;
      rx_len   <= DIV_RST;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if ((rx_state == S_IDLE) || rx_sample) begin
      rx_cnt <= '0;
      rx_len <= div;
      if (rx_state == S_DATA) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end else begin
        rx_idx <= '0;
      end
    end else begin
      rx_cnt <= rx_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_trm_uart_io.sv
// tb/tb_trm_uart_io.sv - scoreboard bench for trm_uart_io
module tb_trm_uart_io;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  ioadr = 6'd0;
  logic        iowr = 1'b0;
  logic        iord = 1'b0;
  logic [31:0] outbus = 32'd0;
  logic [31:0] inbus;
  logic        irq;
  logic        txd;
  logic        rxd;
  logic        loop = 1'b0;
  logic        rxd_drv = 1'b1;
  logic        mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] tx_seen[$];
  logic [7:0] rx_exp[$];

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  trm_uart_io #(.ABASE(6'd0), .DEPTH(16), .DIV_RST(16'd434)) dut (
    .clk(clk), .rst(rst), .ioadr(ioadr), .iowr(iowr), .iord(iord),
    .outbus(outbus), .inbus(inbus), .irq(irq), .txd(txd), .rxd(rxd)
  );

  // Serial decoder for txd, assumes DIV = 8 while enabled.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst && txd === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          b[i] = txd;
        end
        repeat (8) @(negedge clk);
        if (txd === 1'b1) tx_seen.push_back(b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    ioadr = a; outbus = d; iowr = 1'b1;
    @(negedge clk);
    iowr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d0, output logic [31:0] d1);
    ioadr = a; iord = 1'b1;
    #1 d0 = inbus;
    @(negedge clk);
    d1 = inbus;
    @(negedge clk);
    iord = 1'b0;
  endtask

  task automatic store_byte(input logic [7:0] b);
    wr(6'd0, {24'd0, b});
    tx_exp.push_back(b);
    if (loop) rx_exp.push_back(b);
  endtask

  task automatic test_reset();
    logic [31:0] d0, d1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (inbus !== 32'd0) begin errors++; $display("FAIL reset_inbus: got %h expected 0", inbus); end
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 4", d1); end
    rd(6'd2, d0, d1);
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d1); end
    rd(6'd3, d0, d1);
    checks++; if (d1 !== 32'd434) begin errors++; $display("FAIL reset_div: got %h expected %h", d1, 32'd434); end
    rd(6'd0, d0, d1);
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL reset_data_empty: got %h expected 0", d1); end
    rd(6'd4, d0, d1);
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d1); end
  endtask

  task automatic test_div();
    logic [31:0] d0, d1;
    wr(6'd3, 32'd1);
    rd(6'd3, d0, d1);
    checks++; if (d1 !== 32'd4) begin errors++; $display("FAIL div_clamp: got %h expected 4", d1); end
    wr(6'd3, 32'd8);
    rd(6'd3, d0, d1);
    checks++; if (d1 !== 32'd8) begin errors++; $display("FAIL div_set: got %h expected 8", d1); end
    mon_en = 1'b1;
  endtask

  task automatic test_tx_frame();
    logic [31:0] d0, d1;
    logic [79:0] cap, expv;
    logic [9:0]  fr;
    int n;
    fr = {1'b1, 8'hA5, 1'b0};
    store_byte(8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_timeout: got %b expected 0", txd); end
    for (int k = 0; k < 80; k++) begin
      expv[k] = fr[k / 8];
      cap[k]  = txd;
      @(negedge clk);
    end
    checks++; if (cap !== expv) begin errors++; $display("FAIL tx_waveform: got %h expected %h", cap, expv); end
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL tx_idle_status: got %h expected 4", d1); end
    checks++;
    if (tx_seen.size() != tx_exp.size()) begin
      errors++; $display("FAIL tx_frame_count: got %0d expected %0d", tx_seen.size(), tx_exp.size());
    end else if (tx_seen[0] !== tx_exp[0]) begin
      errors++; $display("FAIL tx_frame_byte: got %h expected %h", tx_seen[0], tx_exp[0]);
    end
    tx_seen.delete(); tx_exp.delete();
  endtask

  task automatic test_loopback();
    logic [31:0] d0, d1, s;
    logic [7:0]  e;
    int n;
    loop = 1'b1;
    wr(6'd2, 32'd1);
    store_byte(8'h3C);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL loop_irq_rise: got %b expected 1", irq); end
    rd(6'd0, d0, d1);
    e = rx_exp.pop_front();
    checks++; if (d1 !== {24'd0, e}) begin errors++; $display("FAIL loop_data: got %h expected %h", d1, e); end
    checks++; if (d0 !== d1) begin errors++; $display("FAIL loop_data_stable: got %h expected %h", d0, d1); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL loop_irq_fall: got %b expected 0", irq); end
    rd(6'd1, d0, s);
    checks++; if (s[0] !== 1'b0) begin errors++; $display("FAIL loop_rx_empty: got %b expected 0", s[0]); end
    checks++; if (tx_seen.size() != 1 || tx_seen[0] !== tx_exp[0]) begin
      errors++; $display("FAIL loop_tx_byte: got %0d bytes expected %h", tx_seen.size(), tx_exp[0]);
    end
    tx_seen.delete(); tx_exp.delete();
    wr(6'd2, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, d0, d1;
    logic [7:0]  e;
    loop = 1'b1;
    store_byte(8'h11);
    store_byte(8'h22);
    store_byte(8'h33);
    repeat (300) @(negedge clk);
    ioadr = 6'd0; iord = 1'b1;
    @(negedge clk); a = inbus;
    @(negedge clk);
    @(negedge clk); b = inbus;
    @(negedge clk); iord = 1'b0;
    e = rx_exp.pop_front();
    checks++; if (a !== {24'd0, e}) begin errors++; $display("FAIL b2b_first: got %h expected %h", a, e); end
    e = rx_exp.pop_front();
    checks++; if (b !== {24'd0, e}) begin errors++; $display("FAIL b2b_second: got %h expected %h", b, e); end
    rd(6'd1, d0, d1);
    checks++; if (d1[0] !== 1'b1) begin errors++; $display("FAIL b2b_one_left: got %b expected 1", d1[0]); end
    rd(6'd0, d0, d1);
    e = rx_exp.pop_front();
    checks++; if (d1 !== {24'd0, e}) begin errors++; $display("FAIL b2b_third: got %h expected %h", d1, e); end
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL b2b_final_status: got %h expected 4", d1); end
    checks++; if (tx_seen.size() != 3) begin errors++; $display("FAIL b2b_tx_count: got %0d expected 3", tx_seen.size()); end
    tx_seen.delete(); tx_exp.delete();
    loop = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d0, d1;
    int n;
    store_byte(8'h01);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 16; i++) store_byte(8'h10 + 8'(i));
    wr(6'd0, 32'h99);
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h22) begin errors++; $display("FAIL ovf_status: got %h expected 22", d1); end
    wr(6'd1, 32'd0);
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h02) begin errors++; $display("FAIL ovf_clear: got %h expected 02", d1); end
    repeat (1500) @(negedge clk);
    checks++;
    if (tx_seen.size() != tx_exp.size()) begin
      errors++; $display("FAIL ovf_tx_count: got %0d expected %0d", tx_seen.size(), tx_exp.size());
    end else begin
      for (int i = 0; i < tx_exp.size(); i++) begin
        if (tx_seen[i] !== tx_exp[i]) begin
          errors++; $display("FAIL ovf_tx_byte%0d: got %h expected %h", i, tx_seen[i], tx_exp[i]);
          break;
        end
      end
    end
    tx_seen.delete(); tx_exp.delete();
  endtask

  task automatic test_rx_errors();
    logic [31:0] d0, d1;
    logic [9:0]  fr;
    rxd_drv = 1'b0;
    @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL glitch_status: got %h expected 4", d1); end
    fr = {1'b0, 8'h5A, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = fr[k];
      repeat (8) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h14) begin errors++; $display("FAIL frame_err_status: got %h expected 14", d1); end
    rd(6'd0, d0, d1);
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL frame_err_rx_empty: got %h expected 0", d1); end
    wr(6'd1, 32'd0);
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL frame_err_clear: got %h expected 4", d1); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d0, d1;
    int lows;
    mon_en = 1'b0;
    wr(6'd2, 32'd3);
    store_byte(8'h00);
    repeat (30) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midtx_busy: got %b expected 0", txd); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midtx_txd: got %b expected 1", txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midtx_irq: got %b expected 0", irq); end
    rd(6'd2, d0, d1);
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL midtx_ctrl: got %h expected 0", d1); end
    rd(6'd3, d0, d1);
    checks++; if (d1 !== 32'd434) begin errors++; $display("FAIL midtx_div: got %h expected %h", d1, 32'd434); end
    rd(6'd1, d0, d1);
    checks++; if (d1 !== 32'h4) begin errors++; $display("FAIL midtx_status: got %h expected 4", d1); end
    lows = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midtx_residual: got %0d low cycles expected 0", lows); end
    tx_exp.delete();
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx_frame();
    test_loopback();
    test_back_to_back();
    test_overflow();
    test_rx_errors();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
